sync_up_counter: RTL and testbench

- Synchronous modulo-N up counter: the counting-up counterpart of the team's asynchronous ripple down counter.
- All flops run on a single clock, so there is no ripple skew; Q changes on one edge only.
- Provides parallel load, terminal-count carry for cascading, a wrap pulse, a sticky overflow flag, and an optional one-shot mode driven by a small FSM.
- Intended for timebase and event-count use where glitch-free Q is needed.

---
 rtl/sync_up_counter_if.sv | 25 ++
 rtl/sync_up_counter.sv | 99 +++++++++
 tb/tb_sync_up_counter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/sync_up_counter_if.sv
// Handshake-free control/status bundle for the
// synchronous modulo-N up counter.
interface sync_up_counter_if #(
  parameter int WIDTH = 3
);
  logic             T;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic             CLR_OVF;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             WRAP;
  logic             OVF;
  logic             BUSY;

  modport master (
    output T, LOAD, D, CLR_OVF,
    input  Q, TC, WRAP, OVF, BUSY
  );

  modport slave (
    input  T, LOAD, D, CLR_OVF,
    output Q, TC, WRAP, OVF, BUSY
  );
endinterface

// File: rtl/sync_up_counter.sv
// Synchronous modulo-N up counter with load, cascade carry,
// wrap pulse, sticky overflow and optional one-shot FSM.
module sync_up_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int ONESHOT = 0
) (
  input logic               CLK,
  input logic               RST,
  sync_up_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_C =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0] MOD_C =
    (WIDTH+1)'(MODULUS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             allowed;
  logic             at_max;
  logic             inc;
  logic             wrap_evt;

  // Counting qualifiers shared by datapath and FSM
  always_comb begin
    allowed  = (ONESHOT == 0) || (state_q != S_DONE);
    at_max   = (q_q == MAX_C);
    inc      = bus.T && allowed;
    wrap_evt = inc && at_max && !bus.LOAD;
  end

  // Next count: load (clamped) beats increment
  always_comb begin
    q_d = q_q;
    if (bus.LOAD) begin
      if ({1'b0, bus.D} >= MOD_C) q_d = MAX_C;
      else                        q_d = bus.D;
    end else if (inc) begin
      if (at_max) q_d = '0;
      else        q_d = q_q + WIDTH'(1);
    end
  end

  // Wrap pulse and sticky overflow; a wrap beats a clear
  always_comb begin
    wrap_d = wrap_evt;
    ovf_d  = ovf_q;
    if (bus.CLR_OVF) ovf_d = 1'b0;
    if (wrap_evt)    ovf_d = 1'b1;
  end

  // One-shot sequencing: IDLE -> RUN -> DONE
  always_comb begin
    state_d = state_q;
    if (ONESHOT == 0) begin
      state_d = S_IDLE;
    end else if (bus.LOAD) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (inc) state_d = S_RUN;
        S_RUN:   if (wrap_evt) state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q     <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      q_q     <= q_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.TC   = at_max && bus.T && allowed;
  assign bus.WRAP = wrap_q;
  assign bus.OVF  = ovf_q;
  assign bus.BUSY = (ONESHOT != 0) && (state_q == S_RUN);

endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: three instances cover
// mod-8 free-run, mod-5 free-run and mod-4 one-shot.
module tb_sync_up_counter;

  typedef struct {
    int         u;
    logic       rst;
    logic       t;
    logic       load;
    logic [2:0] d;
    logic       clr;
    logic       tc;
    logic [2:0] q;
    logic       w;
    logic       o;
    logic       b;
    string      nm;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8, rst5, rst4;

  sync_up_counter_if #(.WIDTH(3)) b8 ();
  sync_up_counter_if #(.WIDTH(3)) b5 ();
  sync_up_counter_if #(.WIDTH(3)) b4 ();

  sync_up_counter #(
    .WIDTH(3), .MODULUS(8), .ONESHOT(0)
  ) u8 (.CLK(clk), .RST(rst8), .bus(b8.slave));

  sync_up_counter #(
    .WIDTH(3), .MODULUS(5), .ONESHOT(0)
  ) u5 (.CLK(clk), .RST(rst5), .bus(b5.slave));

  sync_up_counter #(
    .WIDTH(3), .MODULUS(4), .ONESHOT(1)
  ) u4 (.CLK(clk), .RST(rst4), .bus(b4.slave));

  logic [2:0] q_m [3];
  logic tc_m [3];
  logic wr_m [3];
  logic ov_m [3];
  logic bs_m [3];

  assign q_m[0]  = b8.Q;
  assign q_m[1]  = b5.Q;
  assign q_m[2]  = b4.Q;
  assign tc_m[0] = b8.TC;
  assign tc_m[1] = b5.TC;
  assign tc_m[2] = b4.TC;
  assign wr_m[0] = b8.WRAP;
  assign wr_m[1] = b5.WRAP;
  assign wr_m[2] = b4.WRAP;
  assign ov_m[0] = b8.OVF;
  assign ov_m[1] = b5.OVF;
  assign ov_m[2] = b4.OVF;
  assign bs_m[0] = b8.BUSY;
  assign bs_m[1] = b5.BUSY;
  assign bs_m[2] = b4.BUSY;

  int   tests = 0;
  int   fails = 0;
  vec_t tv[$];
  vec_t sb[$];

  function automatic vec_t mk(
    int u, logic rst, logic t, logic load,
    logic [2:0] d, logic clr, logic tc,
    logic [2:0] q, logic w, logic o, logic b,
    string nm
  );
    vec_t v;
    v = '{u, rst, t, load, d, clr,
          tc, q, w, o, b, nm};
    return v;
  endfunction

  task automatic idle_all();
    rst8 = 1'b0; rst5 = 1'b0; rst4 = 1'b0;
    b8.T = 1'b0; b8.LOAD = 1'b0;
    b8.D = '0;   b8.CLR_OVF = 1'b0;
    b5.T = 1'b0; b5.LOAD = 1'b0;
    b5.D = '0;   b5.CLR_OVF = 1'b0;
    b4.T = 1'b0; b4.LOAD = 1'b0;
    b4.D = '0;   b4.CLR_OVF = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    case (v.u)
      0: begin
        rst8 = v.rst; b8.T = v.t; b8.LOAD = v.load;
        b8.D = v.d;   b8.CLR_OVF = v.clr;
      end
      1: begin
        rst5 = v.rst; b5.T = v.t; b5.LOAD = v.load;
        b5.D = v.d;   b5.CLR_OVF = v.clr;
      end
      default: begin
        rst4 = v.rst; b4.T = v.t; b4.LOAD = v.load;
        b4.D = v.d;   b4.CLR_OVF = v.clr;
      end
    endcase
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    idle_all();
    drive(v);
    #1;
    tests++;
    if (tc_m[v.u] !== v.tc) begin
      fails++;
      $display("FAIL %s[%0d] tc: got %b want %b",
               v.nm, idx, tc_m[v.u], v.tc);
    end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests++;
    if ({q_m[e.u], wr_m[e.u], ov_m[e.u], bs_m[e.u]}
        !== {e.q, e.w, e.o, e.b}) begin
      fails++;
      $display("FAIL %s[%0d] q/wrap/ovf/busy: got %0d/%b/%b/%b want %0d/%b/%b/%b",
               e.nm, idx, q_m[e.u], wr_m[e.u],
               ov_m[e.u], bs_m[e.u],
               e.q, e.w, e.o, e.b);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    // mod-8: reset held with T and LOAD
    for (int i = 0; i < 3; i++)
      tv.push_back(mk(0, 1, 1, 1, 3'd5, 0,
                      0, 3'd0, 0, 0, 0, "rst8"));
    // mod-8: free run across the wrap
    for (int i = 0; i < 10; i++)
      tv.push_back(mk(0, 0, 1, 0, 3'd0, 0,
                      (i % 8) == 7,
                      3'((i + 1) % 8),
                      i == 7, i >= 7, 0, "free8"));
    // mod-8: enable gating from Q=2
    tv.push_back(mk(0,0,1,0,3'd0,0, 0,3'd3,0,1,0,"gate"));
    tv.push_back(mk(0,0,0,0,3'd0,0, 0,3'd3,0,1,0,"gate"));
    tv.push_back(mk(0,0,0,0,3'd0,0, 0,3'd3,0,1,0,"gate"));
    tv.push_back(mk(0,0,1,0,3'd0,0, 0,3'd4,0,1,0,"gate"));
    // mod-8: load priority over count, reset over load
    tv.push_back(mk(0,0,0,1,3'd3,0, 0,3'd3,0,1,0,"ld3"));
    tv.push_back(mk(0,0,1,1,3'd6,0, 0,3'd6,0,1,0,"ld6"));
    tv.push_back(mk(0,1,1,1,3'd6,0, 0,3'd0,0,0,0,"rstld"));
    // mod-5: reset then free run
    tv.push_back(mk(1,1,1,1,3'd5,0, 0,3'd0,0,0,0,"rst5"));
    for (int i = 0; i < 7; i++)
      tv.push_back(mk(1, 0, 1, 0, 3'd0, 0,
                      (i % 5) == 4,
                      3'((i + 1) % 5),
                      i == 4, i >= 4, 0, "free5"));
    // mod-5: clear, then clear coincident with wrap
    tv.push_back(mk(1,0,0,0,3'd0,1, 0,3'd2,0,0,0,"clr"));
    tv.push_back(mk(1,0,1,0,3'd0,0, 0,3'd3,0,0,0,"cnt5"));
    tv.push_back(mk(1,0,1,0,3'd0,0, 0,3'd4,0,0,0,"cnt5"));
    tv.push_back(mk(1,0,1,0,3'd0,1, 1,3'd0,1,1,0,"clrwrap"));
    // mod-5: clamp out-of-range loads
    tv.push_back(mk(1,0,0,1,3'd7,0, 0,3'd4,0,1,0,"clamp"));
    tv.push_back(mk(1,0,1,1,3'd7,0, 1,3'd4,0,1,0,"clampt"));
    tv.push_back(mk(1,0,0,0,3'd0,1, 0,3'd4,0,0,0,"clr2"));

    idle_all();
    rst8 = 1'b1; rst5 = 1'b1; rst4 = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++)
      run_vec(tv[i], i);

    // one-shot mod-4: reset, then a full sequence
    run_vec(mk(2,1,1,1,3'd5,0, 0,3'd0,0,0,0,"rst4"), 0);
    for (int i = 0; i < 6; i++)
      run_vec(mk(2, 0, 1, 0, 3'd0, 0,
                 i == 3,
                 (i < 3) ? 3'(i + 1) : 3'd0,
                 i == 3, i >= 3, i < 3, "one"), i);
    // leave DONE via load, restart counting
    run_vec(mk(2,0,1,1,3'd0,0, 0,3'd0,0,1,0,"ldone"), 0);
    run_vec(mk(2,0,1,0,3'd0,0, 0,3'd1,0,1,1,"rerun"), 0);
    // load in RUN drops back to IDLE
    run_vec(mk(2,0,1,1,3'd2,0, 0,3'd2,0,1,0,"ldrun"), 0);
    run_vec(mk(2,0,1,0,3'd0,0, 0,3'd3,0,1,1,"run2"), 0);
    run_vec(mk(2,0,1,0,3'd0,0, 1,3'd0,1,1,0,"wrap4"), 0);
    run_vec(mk(2,0,1,0,3'd0,0, 0,3'd0,0,1,0,"done"), 0);
    // reset also leaves DONE
    run_vec(mk(2,1,0,0,3'd0,0, 0,3'd0,0,0,0,"rstdn"), 0);
    run_vec(mk(2,0,1,0,3'd0,0, 0,3'd1,0,0,1,"rerun2"), 0);

    idle_all();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
